// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU micro-sequencer.
//   - opcode constants for the 2-bit instruction field
//   - micro-sequencer state encoding (IDLE, T1, T2)
package alu_sequencer_pkg;

  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_sequencer_seq_step_decode.sv
// Combinational step decoder for the ALU micro-sequencer.
// Given the current state and the instruction being executed, produces the
// values the top loads into its registers at the next rising edge. The
// strobe and bus outputs here are therefore the values visible during the
// *next* state.
// Ports:
//   state      current sequencer state
//   start      instruction accepted this cycle (only meaningful in IDLE)
//   op         opcode (live input in IDLE, latched opcode otherwise)
//   imm        immediate operand (live input, used only at acceptance)
//   alu_sum    ALU result without the carry bit
//   bus_q      current registered bus value (held when not reloaded)
//   alu_op_q   current ALU select (held when not reloaded)
//   state_nxt  next state
//   bus_nxt    next registered bus value
//   ai_nxt     A load strobe for the next cycle
//   bi_nxt     B load strobe for the next cycle
//   alu_op_nxt ALU select for the next cycle
//   retire     instruction completes at this edge
//   carry_en   capture ALU carry at this edge
//   out_en     capture ALU result into the output register at this edge
module alu_sequencer_seq_step_decode
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  state_t             state,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   imm,
  input  logic [WIDTH-1:0]   alu_sum,
  input  logic [WIDTH-1:0]   bus_q,
  input  logic               alu_op_q,
  output state_t             state_nxt,
  output logic [WIDTH-1:0]   bus_nxt,
  output logic               ai_nxt,
  output logic               bi_nxt,
  output logic               alu_op_nxt,
  output logic               retire,
  output logic               carry_en,
  output logic               out_en
);

  always_comb begin
    state_nxt  = state;
    bus_nxt    = bus_q;
    ai_nxt     = 1'b0;
    bi_nxt     = 1'b0;
    alu_op_nxt = alu_op_q;
    retire     = 1'b0;
    carry_en   = 1'b0;
    out_en     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_T1;
          unique case (op)
            OP_LDA: begin
              bus_nxt = imm;
              ai_nxt  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              bus_nxt    = imm;
              bi_nxt     = 1'b1;
              alu_op_nxt = (op == OP_SUB);
            end
            default: begin
              // OUT: load B with zero so the ALU passes A through.
              bus_nxt    = '0;
              bi_nxt     = 1'b1;
              alu_op_nxt = 1'b0;
            end
          endcase
        end
      end
      ST_T1: begin
        if (op == OP_LDA) begin
          state_nxt = ST_IDLE;
          retire    = 1'b1;
        end else begin
          state_nxt = ST_T2;
          // ADD/SUB write the result back into A during T2.
          ai_nxt    = (op != OP_OUT);
        end
      end
      ST_T2: begin
        state_nxt = ST_IDLE;
        retire    = 1'b1;
        if (op == OP_OUT) begin
          out_en = 1'b1;
        end else begin
          // Keep the result on the bus after T2 so IDLE holds the last value.
          bus_nxt  = alu_sum;
          carry_en = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// ALU micro-sequencer: accepts one instruction at a time over a valid/ready
// handshake and steps it through T1/T2, driving the shared bus, the A/B load
// strobes and the ALU add/sub select of the external register/ALU datapath.
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   instr_valid  instruction offered
//   instr_ready  sequencer can accept an instruction (high only in IDLE)
//   instr_op     opcode: 00 LDA, 01 ADD, 10 SUB, 11 OUT
//   instr_imm    immediate operand
//   alu_res      ALU result {carry, sum}
//   bus_out      value driven onto the bus feeding the A/B registers
//   ai, bi       load A / load B from the bus at the next rising edge
//   alu_op       0 = A+B, 1 = A-B
//   carry        carry flag from the last ADD/SUB
//   out_valid    one-cycle pulse when out_data is updated
//   out_data     value captured by OUT
//   retired      count of completed instructions (wraps)
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [1:0]       instr_op,
  input  logic [WIDTH-1:0] instr_imm,
  input  logic [WIDTH:0]   alu_res,
  output logic [WIDTH-1:0] bus_out,
  output logic             ai,
  output logic             bi,
  output logic             alu_op,
  output logic             carry,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q;
  state_t           state_nxt;
  logic [1:0]       op_q;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] bus_q;
  logic [WIDTH-1:0] bus_nxt;
  logic             ai_nxt;
  logic             bi_nxt;
  logic             alu_op_nxt;
  logic             retire;
  logic             carry_en;
  logic             out_en;
  logic             accept;

  assign accept = instr_valid & instr_ready;
  // The opcode is taken live at acceptance and from the latch afterwards,
  // so later changes on instr_op have no effect.
  assign op_sel = (state_q == ST_IDLE) ? instr_op : op_q;

  // The ALU result only exists once B has been loaded at the end of T1, so
  // during the ADD/SUB write-back cycle the bus carries it straight through
  // for A to capture. The select itself comes from registered state.
  assign bus_out = (state_q == ST_T2 && ai) ? alu_res[WIDTH-1:0] : bus_q;

  alu_sequencer_seq_step_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .state      (state_q),
    .start      (accept),
    .op         (op_sel),
    .imm        (instr_imm),
    .alu_sum    (alu_res[WIDTH-1:0]),
    .bus_q      (bus_q),
    .alu_op_q   (alu_op),
    .state_nxt  (state_nxt),
    .bus_nxt    (bus_nxt),
    .ai_nxt     (ai_nxt),
    .bi_nxt     (bi_nxt),
    .alu_op_nxt (alu_op_nxt),
    .retire     (retire),
    .carry_en   (carry_en),
    .out_en     (out_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      instr_ready <= 1'b1;
      bus_q       <= '0;
      ai          <= 1'b0;
      bi          <= 1'b0;
      alu_op      <= 1'b0;
      carry       <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      retired     <= '0;
    end else begin
      state_q     <= state_nxt;
      instr_ready <= (state_nxt == ST_IDLE);
      bus_q       <= bus_nxt;
      ai          <= ai_nxt;
      bi          <= bi_nxt;
      alu_op      <= alu_op_nxt;
      out_valid   <= out_en;
      if (carry_en) carry <= alu_res[WIDTH];
      if (out_en) out_data <= alu_res[WIDTH-1:0];
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) op_q <= instr_op;
  end

endmodule
